// File: rtl/bus_map.sv
// Shared CPU/memory bus map: region select bit, MMIO register offsets, status bits, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bus_map;

  // address[31] selects the MMIO region; 0 selects RAM.
  localparam int MMIO_BIT = 31;

  // MMIO word offsets (address[3:0]).
  localparam logic [3:0] OFF_CYCLES   = 4'd0;
  localparam logic [3:0] OFF_SCRATCH  = 4'd1;
  localparam logic [3:0] OFF_ERR_ADDR = 4'd2;
  localparam logic [3:0] OFF_STATUS   = 4'd3;

  // Sticky error flag position inside STATUS.
  localparam int STATUS_ERR_BIT = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_t;

endpackage

// File: rtl/simple_ram.sv
// Single-port synchronous RAM, WORDS x 32, write-enable plus read-enable with registered read data.
// Latency: read data appears on o_rdata one cycle after i_re; writes commit at the clock edge.
// Backpressure: none; o_rdata holds its value until the next enabled read.
// Ports: clk; i_we/i_re strobes; i_addr word index; i_wdata write data; o_rdata registered read data.
module simple_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: serves CPU reads/writes from a local RAM or MMIO registers, flags faults.
// Latency: accept in IDLE, one-cycle ready pulse in the following cycle; one access per 2 cycles.
// Backpressure: requester holds read/write until ready; requests are ignored while the response is shown.
// Ports: clk, rst (sync, active-high); read/write/address/din request; dout/ready response.
module mem_responder
  import bus_map::*;
#(
  parameter int RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ready
);

  localparam int AW = $clog2(RAM_WORDS);

  resp_state_t r_state;
  logic        r_ready;
  logic        r_ram_rd;     // response data comes from the RAM read port
  logic [31:0] r_rdata;      // MMIO read result (0 for writes and faults)
  logic [31:0] r_cycles;
  logic [31:0] r_scratch;
  logic [31:0] r_err_addr;
  logic        r_err;

  logic        w_is_mmio;
  logic        w_ram_unmapped;
  logic        w_mmio_unmapped;
  logic        w_fault;
  logic        w_accept;
  logic        w_ram_we;
  logic        w_ram_re;
  logic [31:0] w_ram_rdata;

  // Address decode. Any stray bit between the region bit and the index makes the access unmapped.
  assign w_is_mmio       = address[MMIO_BIT];
  assign w_ram_unmapped  = |address[30:AW];
  assign w_mmio_unmapped = (|address[30:4]) || (address[3:0] > OFF_STATUS);
  assign w_fault         = (read && write) || (w_is_mmio ? w_mmio_unmapped : w_ram_unmapped);

  // RAM strobes are gated by rst so a request held through reset cannot touch memory.
  assign w_accept = (r_state == ST_IDLE) && (read || write) && !rst;
  assign w_ram_we = w_accept && write && !w_fault && !w_is_mmio;
  assign w_ram_re = w_accept && read && !w_fault && !w_is_mmio;

  simple_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (address[AW-1:0]),
    .i_wdata (din),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b0;
      r_ram_rd   <= 1'b0;
      r_rdata    <= '0;
      r_cycles   <= '0;
      r_scratch  <= '0;
      r_err_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      case (r_state)
        ST_IDLE: begin
          r_ready  <= 1'b0;
          r_ram_rd <= 1'b0;
          r_rdata  <= '0;
          if (read || write) begin
            r_state  <= ST_RESP;
            r_ready  <= 1'b1;
            r_ram_rd <= w_ram_re;
            if (w_fault) begin
              r_err      <= 1'b1;
              r_err_addr <= address;
            end else if (w_is_mmio) begin
              if (write) begin
                // CYCLES and ERR_ADDR are read-only: writes fall through and are dropped.
                case (address[3:0])
                  OFF_SCRATCH: r_scratch <= din;
                  OFF_STATUS:  if (din[STATUS_ERR_BIT]) r_err <= 1'b0;
                  default:     ;
                endcase
              end else begin
                case (address[3:0])
                  OFF_CYCLES:   r_rdata <= r_cycles;
                  OFF_SCRATCH:  r_rdata <= r_scratch;
                  OFF_ERR_ADDR: r_rdata <= r_err_addr;
                  OFF_STATUS:   r_rdata <= {31'd0, r_err};
                  default:      r_rdata <= '0;
                endcase
              end
            end
          end
        end
        ST_RESP: begin
          r_state  <= ST_IDLE;
          r_ready  <= 1'b0;
          r_ram_rd <= 1'b0;
          r_rdata  <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign dout  = !r_ready ? 32'd0 : (r_ram_rd ? w_ram_rdata : r_rdata);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: directed accesses push expected responses, a monitor checks them.
// Latency: each access is expected to be acknowledged exactly one cycle after it is driven from IDLE.
// Backpressure: requests are held until ready, then dropped for one cycle before the next access.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ready;

  mem_responder #(.RAM_WORDS(1024)) dut (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .write   (write),
    .address (address),
    .din     (din),
    .dout    (dout),
    .ready   (ready)
  );

  localparam logic [31:0] A_CYC  = 32'h8000_0000;
  localparam logic [31:0] A_SCR  = 32'h8000_0001;
  localparam logic [31:0] A_EADR = 32'h8000_0002;
  localparam logic [31:0] A_STAT = 32'h8000_0003;

  typedef struct {
    logic        chk;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  logic [31:0] tb_cyc;   // posedges since reset, mirrors the free-running counter
  logic [31:0] cyc_off;  // offset applied when the counter is forced

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  function automatic logic [31:0] cyc_now();
    return tb_cyc + cyc_off;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Returns number of negedges until ready was seen, 0 on timeout.
  task automatic wait_rdy(input string nm, output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 8 && !found; i++) begin
      @(negedge clk);
      if (ready) begin
        lat   = i;
        found = 1'b1;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no ready want ready within 8 cycles", nm);
    end
  endtask

  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic chk, input logic [31:0] ev, input string nm);
    int lat;
    sb.push_back('{chk, ev, nm});
    read    = rd;
    write   = wr;
    address = a;
    din     = d;
    wait_rdy(nm, lat);
    if (lat != 0) chk32({nm, " latency"}, 32'(lat), 32'd1);
    else          void'(sb.pop_back());
    read  = 1'b0;
    write = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ev, input string nm);
    xact(1'b1, 1'b0, a, 32'd0, 1'b1, ev, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    xact(1'b0, 1'b1, a, d, 1'b0, 32'd0, nm);
  endtask

  initial begin
    int lat;
    total   = 0;
    bad     = 0;
    cyc_off = 32'd0;
    rst     = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    address = 32'd0;
    din     = 32'd0;

    // Monitor: every acknowledged response is matched against the scoreboard head.
    fork
      forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected ready: got ready=1 want no response pending");
          end else begin
            e = sb.pop_front();
            if (e.chk) chk32(e.nm, dout, e.val);
          end
        end else if (!rst) begin
          chk32("dout while idle", dout, 32'd0);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk32("reset ready", {31'd0, ready}, 32'd0);
    chk32("reset dout", dout, 32'd0);
    rst = 1'b0;

    // RAM write then read-back, status stays clean.
    wr(32'h0000_0010, 32'hDEAD_BEEF, "ram wr 0x10");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram rd 0x10");
    rd(A_STAT, 32'd0, "status clean 1");
    wr(32'h0000_03FF, 32'hCAFE_F00D, "ram wr top");
    rd(32'h0000_03FF, 32'hCAFE_F00D, "ram rd top");

    // MMIO scratch and read-only counter.
    wr(A_SCR, 32'h1234_5678, "scratch wr");
    rd(A_SCR, 32'h1234_5678, "scratch rd");
    wr(A_CYC, 32'h0000_FFFF, "cycles wr");
    rd(A_CYC, cyc_now(), "cycles after wr");
    rd(A_STAT, 32'd0, "status clean 2");

    // Unmapped RAM access.
    rd(32'h0000_0400, 32'd0, "unmapped ram dout");
    rd(A_STAT, 32'd1, "status err set");
    rd(A_EADR, 32'h0000_0400, "err addr ram");
    wr(A_STAT, 32'd1, "status clear");
    rd(A_STAT, 32'd0, "status cleared");

    // Unmapped MMIO offsets.
    rd(32'h8000_0004, 32'd0, "unmapped mmio 4 dout");
    rd(A_EADR, 32'h8000_0004, "err addr mmio 4");
    wr(32'h8000_0010, 32'h5555_5555, "unmapped mmio hi wr");
    rd(A_EADR, 32'h8000_0010, "err addr mmio hi");
    rd(A_SCR, 32'h1234_5678, "scratch untouched");
    wr(A_STAT, 32'd1, "status clear 2");

    // Simultaneous read and write is a fault and leaves RAM alone.
    wr(32'h0000_0005, 32'h0000_00A5, "ram wr 0x5");
    xact(1'b1, 1'b1, 32'h0000_0005, 32'h0000_1234, 1'b1, 32'd0, "rd+wr dout");
    rd(32'h0000_0005, 32'h0000_00A5, "ram 0x5 kept");
    rd(A_STAT, 32'd1, "status after rd+wr");
    rd(A_EADR, 32'h0000_0005, "err addr rd+wr");
    wr(A_STAT, 32'd1, "status clear 3");

    // Held request: two CYCLES reads accepted 2 cycles apart.
    sb.push_back('{1'b1, cyc_now(), "cycles held 0"});
    sb.push_back('{1'b1, cyc_now() + 32'd2, "cycles held 1"});
    read    = 1'b1;
    address = A_CYC;
    wait_rdy("cycles held 0", lat);
    chk32("held first latency", 32'(lat), 32'd1);
    wait_rdy("cycles held 1", lat);
    chk32("held second spacing", 32'(lat), 32'd2);
    read = 1'b0;
    @(negedge clk);

    // Counter wrap.
    force dut.r_cycles = 32'hFFFF_FFFE;
    cyc_off = 32'hFFFF_FFFE - tb_cyc;
    #1;
    release dut.r_cycles;
    @(negedge clk);
    rd(A_CYC, 32'hFFFF_FFFF, "cycles max");
    rd(A_CYC, 32'h0000_0001, "cycles wrapped");

    // Reset while a response is being presented.
    wr(32'h0000_0030, 32'h0000_0077, "ram wr 0x30");
    rd(32'h0000_0401, 32'd0, "fault before reset");
    sb.push_back('{1'b0, 32'd0, "wr 0x31 reset"});
    write   = 1'b1;
    address = 32'h0000_0031;
    din     = 32'h0000_0099;
    @(negedge clk);
    chk32("resp before reset", {31'd0, ready}, 32'd1);
    rst     = 1'b1;
    write   = 1'b0;
    cyc_off = 32'd0;
    @(negedge clk);
    chk32("ready after reset", {31'd0, ready}, 32'd0);
    chk32("dout after reset", dout, 32'd0);
    rst = 1'b0;
    rd(A_SCR, 32'd0, "scratch reset");
    rd(A_STAT, 32'd0, "status reset");
    rd(A_EADR, 32'd0, "err addr reset");
    rd(A_CYC, cyc_now(), "cycles reset");
    rd(32'h0000_0031, 32'h0000_0099, "ram 0x31 kept");
    rd(32'h0000_0030, 32'h0000_0077, "ram 0x30 kept");

    chk32("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
